// File: rtl/alu_1_arbiter.sv
// Round-robin arbiter sharing one alu_1 among NUM_REQ requesters, with a latency-matched
// tag pipeline that routes each ALU result back to its owner as a one-hot response.
module alu_1_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ACTION_LEN  = 25,
  parameter int unsigned DATA_WIDTH  = 48,
  parameter int unsigned ALU_LATENCY = 3,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              cfg_enable,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ACTION_LEN-1:0]   req_action,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_op1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_op2,
  output logic [ACTION_LEN-1:0]           alu_action,
  output logic                            alu_action_valid,
  output logic [DATA_WIDTH-1:0]           alu_operand_1,
  output logic [DATA_WIDTH-1:0]           alu_operand_2,
  input  logic [DATA_WIDTH-1:0]           alu_result,
  input  logic                            alu_result_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [NUM_REQ*CNT_WIDTH-1:0]    cnt_issued,
  output logic                            err_orphan,
  output logic                            err_lost
);

  localparam int unsigned IDW       = $clog2(NUM_REQ);
  localparam int unsigned TAG_DEPTH = ALU_LATENCY + 1;

  logic [IDW-1:0]        rr_ptr;
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    grant;
  logic [IDW-1:0]        grant_id;
  logic                  grant_any;
  logic [IDW-1:0]        search_idx;

  logic [ACTION_LEN-1:0] sel_action;
  logic [DATA_WIDTH-1:0] sel_op1;
  logic [DATA_WIDTH-1:0] sel_op2;

  logic [TAG_DEPTH-1:0]  tag_vld;
  logic [IDW-1:0]        tag_id [TAG_DEPTH];
  logic                  tag_out_vld;
  logic [IDW-1:0]        tag_out_id;

  logic [CNT_WIDTH-1:0]  cnt [NUM_REQ];

  // Search from rr_ptr upward; IDW-bit index arithmetic provides the wrap.
  always_comb begin
    eligible   = req_valid & cfg_enable;
    grant      = '0;
    grant_id   = '0;
    grant_any  = 1'b0;
    search_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      search_idx = rr_ptr + IDW'(k);
      if (!grant_any && eligible[search_idx]) begin
        grant_any = 1'b1;
        grant_id  = search_idx;
      end
    end
    if (grant_any) grant[grant_id] = 1'b1;
  end

  assign req_ready = grant;

  always_comb begin
    sel_action = '0;
    sel_op1    = '0;
    sel_op2    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_action = req_action[k*ACTION_LEN +: ACTION_LEN];
        sel_op1    = req_op1[k*DATA_WIDTH +: DATA_WIDTH];
        sel_op2    = req_op2[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr           <= '0;
      alu_action       <= '0;
      alu_action_valid <= 1'b0;
      alu_operand_1    <= '0;
      alu_operand_2    <= '0;
    end else begin
      alu_action_valid <= grant_any;
      if (grant_any) begin
        rr_ptr        <= grant_id + IDW'(1);
        alu_action    <= sel_action;
        alu_operand_1 <= sel_op1;
        alu_operand_2 <= sel_op2;
      end else begin
        alu_action    <= '0;
        alu_operand_1 <= '0;
        alu_operand_2 <= '0;
      end
    end
  end

  // Stage 0 loads alongside the alu_* registers so the last stage lines up with alu_result_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      for (int unsigned i = 0; i < TAG_DEPTH; i++) tag_id[i] <= '0;
    end else begin
      tag_vld   <= {tag_vld[TAG_DEPTH-2:0], grant_any};
      tag_id[0] <= grant_id;
      for (int unsigned i = 1; i < TAG_DEPTH; i++) tag_id[i] <= tag_id[i-1];
    end
  end

  assign tag_out_vld = tag_vld[TAG_DEPTH-1];
  assign tag_out_id  = tag_id[TAG_DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data   <= '0;
      rsp_valid  <= '0;
      err_orphan <= 1'b0;
      err_lost   <= 1'b0;
    end else begin
      rsp_data  <= alu_result_valid ? alu_result : '0;
      rsp_valid <= (tag_out_vld && alu_result_valid) ? (NUM_REQ'(1) << tag_out_id) : '0;
      if (alu_result_valid && !tag_out_vld) err_orphan <= 1'b1;
      if (tag_out_vld && !alu_result_valid) err_lost   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) cnt[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (grant[k] && (cnt[k] != '1)) cnt[k] <= cnt[k] + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    cnt_issued = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) cnt_issued[k*CNT_WIDTH +: CNT_WIDTH] = cnt[k];
  end

endmodule
